wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file. Drives its write port: ctrl_writeEnable, ctrl_writeReg and data_writeReg.
- Merges two writeback sources:
  - the in-order pipeline (ALU/load) result, which has priority and no backpressure;
  - the multi-cycle multdiv result, buffered in a small in-order FIFO and drained in idle write slots.
- Publishes read-hazard flags against the register-file read addresses.
- Forces a pipeline stall if the multdiv queue is starved.

---
 rtl/wb_arbiter_pkg.sv | 14 +
 rtl/wb_fifo.sv | 95 +++++++++
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and its multdiv result queue.
package wb_arbiter_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] R0 = '0;

  typedef enum logic [0:0] {
    StNormal = 1'b0,
    StForce  = 1'b1
  } starve_state_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of multdiv results. Entries can be invalidated by destination register
// so a younger pipeline write to the same register suppresses the stale result.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  logic [REG_W-1:0]                push_rd_i,
  input  logic [DATA_W-1:0]               push_data_i,
  input  logic                            pop_i,
  input  logic                            squash_i,
  input  logic [REG_W-1:0]                squash_rd_i,
  output logic                            head_valid_o,
  output logic [REG_W-1:0]                head_rd_o,
  output logic [DATA_W-1:0]               head_data_o,
  output logic [$clog2(DEPTH+1)-1:0]      count_o,
  output logic [DEPTH-1:0]                ent_valid_o,
  output logic [DEPTH-1:0][REG_W-1:0]     ent_rd_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][REG_W-1:0]   rd_q, rd_d;
  logic [DEPTH-1:0][DATA_W-1:0]  data_q, data_d;
  logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]               count_q, count_d;

  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (squash_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rd_q[i] == squash_rd_i) begin
          valid_d[i] = 1'b0;
        end
      end
    end

    // Popped slots drop their valid bit so hazard compares only see live entries.
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end

    if (push_i) begin
      valid_d[wr_ptr_q] = !(squash_i && (push_rd_i == squash_rd_i));
      rd_d[wr_ptr_q]    = push_rd_i;
      data_d[wr_ptr_q]  = push_data_i;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end

    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid_o = valid_q[rd_ptr_q];
  assign head_rd_o    = rd_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign count_o      = count_q;
  assign ent_valid_o  = valid_q;
  assign ent_rd_o     = rd_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: the pipeline owns the register-file write port, queued multdiv
// results fill idle slots, and a starvation FSM stalls the pipeline to drain the queue.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  input  logic [REG_W-1:0]  ctrl_readRegA,
  input  logic [REG_W-1:0]  ctrl_readRegB,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              stall_pipe,
  output logic              ctrl_writeEnable,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic                         pipe_win;
  logic                         fifo_nonempty;
  logic                         push;
  logic                         pop;
  logic                         head_valid;
  logic [REG_W-1:0]             head_rd;
  logic [DATA_W-1:0]            head_data;
  logic [CntW-1:0]              count;
  logic [CntW-1:0]              count_next;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][REG_W-1:0]  ent_rd;

  logic                         we_q, we_d;
  logic [REG_W-1:0]             wreg_q, wreg_d;
  logic [DATA_W-1:0]            wdata_q, wdata_d;

  starve_state_e                state_q, state_d;
  logic [StarveW-1:0]           starve_cnt_q, starve_cnt_d;

  // A pipeline write to r0 is a no-op and leaves the slot free for the queue.
  assign pipe_win      = pipe_we && (pipe_rd != R0);
  assign fifo_nonempty = (count != '0);
  assign md_ready      = ctrl_reset && (count < CntW'(DEPTH));
  assign push          = md_valid && md_ready && (md_rd != R0);
  assign pop           = !pipe_win && fifo_nonempty;
  assign count_next    = count + CntW'(push) - CntW'(pop);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clock),
    .rst_ni       (ctrl_reset),
    .push_i       (push),
    .push_rd_i    (md_rd),
    .push_data_i  (md_data),
    .pop_i        (pop),
    .squash_i     (pipe_win),
    .squash_rd_i  (pipe_rd),
    .head_valid_o (head_valid),
    .head_rd_o    (head_rd),
    .head_data_o  (head_data),
    .count_o      (count),
    .ent_valid_o  (ent_valid),
    .ent_rd_o     (ent_rd)
  );

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (pipe_win) begin
      we_d    = 1'b1;
      wreg_d  = pipe_rd;
      wdata_d = pipe_data;
    end else if (pop && head_valid) begin
      we_d    = 1'b1;
      wreg_d  = head_rd;
      wdata_d = head_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      StNormal: begin
        if (fifo_nonempty && pipe_win) begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end else begin
          starve_cnt_d = '0;
        end
        if (starve_cnt_d == StarveW'(STARVE_LIMIT)) begin
          state_d      = StForce;
          starve_cnt_d = '0;
        end
      end
      StForce: begin
        if (count_next == '0) begin
          state_d = StNormal;
        end
      end
      default: state_d = StNormal;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      we_q         <= 1'b0;
      wreg_q       <= '0;
      wdata_q      <= '0;
      state_q      <= StNormal;
      starve_cnt_q <= '0;
    end else begin
      we_q         <= we_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // The value on the write port is not committed until the end of this cycle, so it
  // still counts as pending for readers.
  always_comb begin
    hazard_a = we_q && (wreg_q == ctrl_readRegA);
    hazard_b = we_q && (wreg_q == ctrl_readRegB);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hazard_a = hazard_a | (ent_valid[i] && (ent_rd[i] == ctrl_readRegA));
      hazard_b = hazard_b | (ent_valid[i] && (ent_rd[i] == ctrl_readRegB));
    end
    if (ctrl_readRegA == R0) hazard_a = 1'b0;
    if (ctrl_readRegB == R0) hazard_b = 1'b0;
  end

  assign stall_pipe       = (state_q == StForce);
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random checks of wb_arbiter against a queue-based model of the writeback rules.
module tb_wb_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic [4:0]  ctrl_readRegA = '0;
  logic [4:0]  ctrl_readRegB = '0;
  logic        hazard_a;
  logic        hazard_b;
  logic        stall_pipe;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  always #5 clock = ~clock;

  wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .pipe_we          (pipe_we),
    .pipe_rd          (pipe_rd),
    .pipe_data        (pipe_data),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .hazard_a         (hazard_a),
    .hazard_b         (hazard_b),
    .stall_pipe       (stall_pipe),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit [31:0] d;
  } ent_t;

  ent_t      mq[$];
  bit        m_we;
  bit [4:0]  m_reg;
  bit [31:0] m_data;
  bit        m_force;
  int        m_blk;
  int        total = 0;
  int        bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_haz(input bit [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_we && m_reg == a) return 1'b1;
    foreach (mq[i]) if (mq[i].v && mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_we    = 1'b0;
    m_reg   = '0;
    m_data  = '0;
    m_force = 1'b0;
    m_blk   = 0;
  endtask

  task automatic drive(input bit pwe, input bit [4:0] prd, input bit [31:0] pd,
                       input bit mv, input bit [4:0] mrd, input bit [31:0] md);
    pipe_we   = pwe;
    pipe_rd   = prd;
    pipe_data = pd;
    md_valid  = mv;
    md_rd     = mrd;
    md_data   = md;
  endtask

  // One clock cycle: check combinational outputs, advance the model, check the write port.
  task automatic step(input string tag);
    bit   pw;
    bit   acc;
    int   n0;
    ent_t e;
    #1;
    chk({tag, "_ready"}, md_ready, 32'(mq.size() < DEPTH));
    chk({tag, "_stall"}, stall_pipe, m_force);
    chk({tag, "_hazA"}, hazard_a, m_haz(ctrl_readRegA));
    chk({tag, "_hazB"}, hazard_b, m_haz(ctrl_readRegB));
    chk({tag, "_proto"}, stall_pipe && pipe_we, 0);
    pw  = pipe_we && (pipe_rd != 5'd0);
    n0  = mq.size();
    acc = md_valid && (n0 < DEPTH) && (md_rd != 5'd0);
    if (pw) foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].v = 1'b0;
    if (pw) begin
      m_we   = 1'b1;
      m_reg  = pipe_rd;
      m_data = pipe_data;
    end else if (n0 > 0) begin
      e    = mq.pop_front();
      m_we = e.v;
      if (e.v) begin
        m_reg  = e.rd;
        m_data = e.d;
      end
    end else begin
      m_we = 1'b0;
    end
    if (acc) begin
      e.v  = !(pw && md_rd == pipe_rd);
      e.rd = md_rd;
      e.d  = md_data;
      mq.push_back(e);
    end
    if (!m_force) begin
      m_blk = (n0 > 0 && pw) ? m_blk + 1 : 0;
      if (m_blk == LIMIT) begin
        m_force = 1'b1;
        m_blk   = 0;
      end
    end else if (mq.size() == 0) begin
      m_force = 1'b0;
    end
    @(posedge clock);
    #1;
    chk({tag, "_we"}, ctrl_writeEnable, m_we);
    if (m_we) begin
      chk({tag, "_reg"}, ctrl_writeReg, m_reg);
      chk({tag, "_data"}, data_writeReg, m_data);
    end
  endtask

  initial begin
    m_reset();
    #3;
    chk("rst_we", ctrl_writeEnable, 0);
    chk("rst_reg", ctrl_writeReg, 0);
    chk("rst_data", data_writeReg, 0);
    chk("rst_stall", stall_pipe, 0);
    chk("rst_ready", md_ready, 0);
    #9 ctrl_reset = 1'b1;
    @(posedge clock);
    #1;

    // Pipeline-only traffic
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    step("pipe5");
    chk("pipe5_we_c", ctrl_writeEnable, 1);
    chk("pipe5_reg_c", ctrl_writeReg, 5);
    chk("pipe5_data_c", data_writeReg, 32'hDEADBEEF);
    drive(1, 0, 32'h11111111, 0, 0, 0);
    step("pipe0");
    chk("pipe0_we_c", ctrl_writeEnable, 0);

    // Multdiv into an idle slot, with a reader of r7
    ctrl_readRegA = 5'd7;
    drive(0, 0, 0, 1, 7, 32'h12345678);
    step("md_enq");
    drive(0, 0, 0, 0, 0, 0);
    step("md_deq");
    chk("md_we_c", ctrl_writeEnable, 1);
    chk("md_reg_c", ctrl_writeReg, 7);
    chk("md_data_c", data_writeReg, 32'h12345678);
    chk("md_haz_port_c", hazard_a, 1);
    step("md_port");
    chk("md_haz_clr_c", hazard_a, 0);
    ctrl_readRegA = 5'd0;

    // Fill the queue while the pipeline keeps the slot
    drive(1, 1, 32'hA0, 1, 10, 32'hB0);
    step("full1");
    drive(1, 2, 32'hA1, 1, 11, 32'hB1);
    step("full2");
    chk("full_ready_c", md_ready, 0);
    drive(1, 3, 32'hA2, 1, 12, 32'hB2);
    step("full3");
    chk("full3_reg_c", ctrl_writeReg, 3);
    drive(0, 0, 0, 0, 0, 0);
    step("drain1");
    step("drain2");
    step("drain3");

    // Starvation: one queued entry blocked for LIMIT cycles
    drive(1, 4, 32'hC0, 1, 13, 32'hC1);
    step("stv_enq");
    for (int i = 0; i < int'(LIMIT); i++) begin
      drive(1, 5'(14 + i), 32'(i), 0, 0, 0);
      step("stv_blk");
    end
    chk("stv_stall_c", stall_pipe, 1);
    drive(0, 0, 0, 0, 0, 0);
    step("stv_drain");
    chk("stv_we_c", ctrl_writeEnable, 1);
    chk("stv_reg_c", ctrl_writeReg, 13);
    chk("stv_unstall_c", stall_pipe, 0);

    // WAW squash, across cycles and within the same cycle
    ctrl_readRegB = 5'd9;
    drive(1, 3, 32'h33, 1, 9, 32'h1);
    step("waw_enq");
    drive(1, 9, 32'h2, 0, 0, 0);
    step("waw_pipe");
    chk("waw_data_c", data_writeReg, 32'h2);
    drive(0, 0, 0, 0, 0, 0);
    step("waw_deq");
    chk("waw_sq_we_c", ctrl_writeEnable, 0);
    drive(1, 9, 32'h4, 1, 9, 32'h5);
    step("waw_same");
    drive(0, 0, 0, 0, 0, 0);
    step("waw_same_deq");
    chk("waw_same_we_c", ctrl_writeEnable, 0);
    ctrl_readRegB = 5'd0;

    // Asynchronous reset with two results queued and a write on the port
    drive(1, 5, 32'h55, 1, 20, 32'h66);
    step("ar_fill1");
    drive(1, 6, 32'h56, 1, 21, 32'h67);
    step("ar_fill2");
    drive(0, 0, 0, 0, 0, 0);
    #2 ctrl_reset = 1'b0;
    m_reset();
    #1;
    chk("ar_we", ctrl_writeEnable, 0);
    chk("ar_reg", ctrl_writeReg, 0);
    chk("ar_data", data_writeReg, 0);
    chk("ar_stall", stall_pipe, 0);
    chk("ar_ready", md_ready, 0);
    @(posedge clock);
    #2 ctrl_reset = 1'b1;
    #1;
    chk("ar_rel_ready", md_ready, 1);
    step("ar_idle");
    chk("ar_idle_we_c", ctrl_writeEnable, 0);

    // Random traffic with frequent register collisions
    for (int k = 0; k < 400; k++) begin
      pipe_we       = m_force ? 1'b0 : ($urandom_range(0, 99) < 55);
      pipe_rd       = 5'($urandom_range(0, 7));
      pipe_data     = $urandom;
      md_valid      = 1'($urandom_range(0, 1));
      md_rd         = 5'($urandom_range(0, 7));
      md_data       = $urandom;
      ctrl_readRegA = 5'($urandom_range(0, 7));
      ctrl_readRegB = 5'($urandom_range(0, 7));
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
